// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: recovers start/data/parity/stop bits on sample_tick,
// drops bad frames with one-cycle error pulses, and queues good words for a valid/ready consumer.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          uart_stream,
  output logic [DATA_BITS-1:0]          uart_word,
  output logic                          valid,
  input  logic                          word_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [2:0]                    fsm_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic sync_q, rx_q, rx;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic par_ok_q, par_ok_d, stop_bad_q, stop_bad_d;
  logic push_d, perr_d, ferr_d;
  logic push_q, perr_q, ferr_q;
  logic [DATA_BITS-1:0] wdata_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= uart_stream;
      rx_q   <= sync_q;
    end
  end
  assign rx = rx_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      par_ok_q   <= 1'b1;
      stop_bad_q <= 1'b0;
      push_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      par_ok_q   <= par_ok_d;
      stop_bad_q <= stop_bad_d;
      push_q     <= push_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      wdata_q    <= sr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    par_ok_d   = par_ok_q;
    stop_bad_d = stop_bad_q;
    push_d     = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_tick && !rx) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (cnt_q == HALF_LAST) begin
            cnt_d      = '0;
            bit_d      = '0;
            par_ok_d   = 1'b1;
            stop_bad_d = 1'b0;
            state_d    = rx ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            sr_d  = {rx, sr_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (sample_tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d    = '0;
            par_ok_d = (PARITY_MODE == 1) ? (rx == ^sr_q) : (rx == ~^sr_q);
            state_d  = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            if (bit_q == STOP_LAST) begin
              bit_d = '0;
              // A bad stop bit outranks a parity failure.
              if (stop_bad_q || !rx) begin
                ferr_d  = 1'b1;
                state_d = S_BREAK;
              end else if (!par_ok_q) begin
                perr_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                push_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              bit_d      = bit_q + BW'(1);
              stop_bad_d = stop_bad_q | !rx;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_BREAK: begin
        if (sample_tick && rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO; head word and valid are registered from the next-state view.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] count_q, count_d, remain;
  logic [DATA_BITS-1:0] word_q, word_d, head_d;
  logic valid_q, valid_d, pop, full, wr_en, ovr_d;
  logic perr_out_q, ferr_out_q, ovr_q;

  always_comb begin
    pop      = valid_q && word_ready;
    full     = (count_q == LW'(FIFO_DEPTH));
    wr_en    = push_q && (!full || pop);
    ovr_d    = push_q && full && !pop;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + LW'(1);
    else if (!wr_en && pop) count_d = count_q - LW'(1);
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    remain   = pop ? count_q - LW'(1) : count_q;
    head_d   = (remain == '0) ? wdata_q : mem_q[rd_ptr_d];
    valid_d  = (count_d != '0);
    word_d   = valid_d ? head_d : word_q;
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_q;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_q;
      ferr_out_q <= ferr_q;
      ovr_q      <= ovr_d;
    end
  end

  assign uart_word  = word_q;
  assign valid      = valid_q;
  assign level      = count_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: default framing instance plus a 7N2 instance,
// scoreboard queues of expected words popped on each handshake transfer.
module tb_uart_rx_frame;
  localparam int TDIV = 2;
  localparam int OS   = 16;
  localparam int BIT  = OS * TDIV;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic tick = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tick <= ~tick;

  logic rst1, line1, ready1, valid1, perr1, ferr1, ovr1;
  logic [7:0] word1;
  logic [2:0] level1, st1;
  logic rst2, line2, ready2, valid2, perr2, ferr2, ovr2;
  logic [6:0] word2;
  logic [2:0] level2, st2;

  uart_rx_frame dut1 (
    .clk_sys(clk), .rst(rst1), .sample_tick(tick), .uart_stream(line1),
    .uart_word(word1), .valid(valid1), .word_ready(ready1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1),
    .level(level1), .fsm_state(st1));

  uart_rx_frame #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
    .clk_sys(clk), .rst(rst2), .sample_tick(tick), .uart_stream(line2),
    .uart_word(word2), .valid(valid2), .word_ready(ready2),
    .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2),
    .level(level2), .fsm_state(st2));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];

  int perr1_n = 0, ferr1_n = 0, ovr1_n = 0, ev2_n = 0;
  always @(negedge clk) begin
    if (perr1 === 1'b1) perr1_n++;
    if (ferr1 === 1'b1) ferr1_n++;
    if (ovr1 === 1'b1) ovr1_n++;
    if ((perr2 | ferr2 | ovr2) !== 1'b0) ev2_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int sel, input logic v);
    if (sel == 1) line1 = v; else line2 = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input int pmode, input bit flip, input int nstop, input logic stop_v);
    logic p;
    p = 1'b0;
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(sel, data[i]);
      p = p ^ data[i];
    end
    if (pmode != 0) begin
      if (pmode == 2) p = ~p;
      send_bit(sel, p ^ flip);
    end
    for (int i = 0; i < nstop; i++) send_bit(sel, stop_v);
  endtask

  task automatic wait_valid(input int sel, input string tag);
    int n;
    n = 0;
    while (((sel == 1) ? valid1 : valid2) !== 1'b1 && n < 20 * BIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, (sel == 1) ? valid1 : valid2, 1);
  endtask

  task automatic pop_one(input int sel, input string tag);
    logic [W-1:0] e;
    if (sel == 1) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check(tag, word1, e);
      ready1 = 1'b1;
      @(negedge clk);
      ready1 = 1'b0;
    end else begin
      e = (exp2_q.size() != 0) ? exp2_q.pop_front() : 'x;
      check(tag, {1'b0, word2}, e);
      ready2 = 1'b1;
      @(negedge clk);
      ready2 = 1'b0;
    end
  endtask

  initial begin
    int p0, f0, o0, e0, bad, exp_ovr;
    rst1 = 1'b1; rst2 = 1'b1;
    line1 = 1'b1; line2 = 1'b1;
    ready1 = 1'b0; ready2 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid1", valid1, 0);
    check("rst_level1", level1, 0);
    check("rst_word1", word1, 0);
    check("rst_errs1", {perr1, ferr1, ovr1}, 0);
    check("rst_state1", st1, 0);
    check("rst_valid2", valid2, 0);
    check("rst_level2", level2, 0);
    rst1 = 1'b0; rst2 = 1'b0;
    repeat (BIT) @(negedge clk);

    // Good 0xA5, odd parity, one stop bit.
    send_frame(1, 9'h0A5, 8, 2, 0, 1, 1'b1);
    exp_q.push_back(8'hA5);
    wait_valid(1, "t1_valid");
    check("t1_level", level1, 1);
    check("t1_no_errs", perr1_n + ferr1_n + ovr1_n, 0);
    pop_one(1, "t1_word");
    check("t1_valid_drop", valid1, 0);
    check("t1_level_drop", level1, 0);

    // Inverted parity bit.
    p0 = perr1_n;
    send_frame(1, 9'h0A5, 8, 2, 1, 1, 1'b1);
    repeat (BIT) @(negedge clk);
    check("t2_perr_pulses", perr1_n - p0, 1);
    check("t2_valid", valid1, 0);
    check("t2_level", level1, 0);

    // Bad parity and low stop bit, line held low: one frame_err, parity suppressed.
    p0 = perr1_n; f0 = ferr1_n;
    send_frame(1, 9'h0A5, 8, 2, 1, 1, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    line1 = 1'b1;
    repeat (BIT) @(negedge clk);
    check("t3_ferr_pulses", ferr1_n - f0, 1);
    check("t3_perr_suppressed", perr1_n - p0, 0);
    check("t3_level", level1, 0);
    send_frame(1, 9'h03C, 8, 2, 0, 1, 1'b1);
    exp_q.push_back(8'h3C);
    wait_valid(1, "t3_valid");
    pop_one(1, "t3_word");

    // 0.3-bit glitch on the idle line.
    e0 = perr1_n + ferr1_n + ovr1_n;
    bad = 0;
    line1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid1 !== 1'b0 || level1 !== 3'd0) bad++;
    end
    line1 = 1'b1;
    for (int i = 0; i < 2 * BIT; i++) begin
      @(negedge clk);
      if (valid1 !== 1'b0 || level1 !== 3'd0) bad++;
    end
    check("t4_quiet", bad, 0);
    check("t4_no_pulses", perr1_n + ferr1_n + ovr1_n - e0, 0);
    send_frame(1, 9'h055, 8, 2, 0, 1, 1'b1);
    exp_q.push_back(8'h55);
    wait_valid(1, "t4_valid");
    pop_one(1, "t4_word");

    // Five back-to-back frames into a four-deep FIFO with no consumer.
    o0 = ovr1_n;
    exp_ovr = 0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(1, 9'(v), 8, 2, 0, 1, 1'b1);
      if (exp_q.size() < 4) exp_q.push_back(W'(v));
      else exp_ovr++;
    end
    repeat (4) @(negedge clk);
    check("t5_level_full", level1, 4);
    check("t5_overrun", ovr1_n - o0, exp_ovr);
    check("t5_valid", valid1, 1);
    ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check("t5_drain_valid", valid1, 1);
      check("t5_drain_word", word1, e);
      @(negedge clk);
    end
    ready1 = 1'b0;
    check("t5_empty_valid", valid1, 0);
    check("t5_empty_level", level1, 0);

    // 7 data bits, no parity, two stop bits.
    send_frame(2, 9'h05A, 7, 0, 0, 2, 1'b1);
    exp2_q.push_back(8'h5A);
    wait_valid(2, "t6_valid");
    check("t6_level", level2, 1);
    pop_one(2, "t6_word");

    // Reset in the middle of a second frame.
    e0 = ev2_n;
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    rst2 = 1'b1;
    line2 = 1'b1;
    #1;
    check("t6_rst_valid", valid2, 0);
    check("t6_rst_level", level2, 0);
    check("t6_rst_word", word2, 0);
    check("t6_rst_errs", {perr2, ferr2, ovr2}, 0);
    check("t6_rst_state", st2, 0);
    @(negedge clk);
    rst2 = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("t6_no_push", level2, 0);
    check("t6_no_pulses", ev2_n - e0, 0);
    send_frame(2, 9'h011, 7, 0, 0, 2, 1'b1);
    exp2_q.push_back(8'h11);
    wait_valid(2, "t6_recover_valid");
    pop_one(2, "t6_recover_word");

    check("sb1_empty", exp_q.size(), 0);
    check("sb2_empty", exp2_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
